// File: rtl/coef_to_digits_if.sv
`default_nettype none
// ============================================================================
// Module   : coef_to_digits_if
// Brief    : Request/result bundle between coefficient source and BCD converter
// Revision : 1.0
// ============================================================================
interface coef_to_digits_if #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic                  plus;
  logic                  overflow;

  modport master (
    output start, value,
    input  busy, done, digits, plus, overflow
  );

  modport slave (
    input  start, value,
    output busy, done, digits, plus, overflow
  );
endinterface
`default_nettype wire

// File: rtl/coef_to_digits.sv
`default_nettype none
// ============================================================================
// Module   : coef_to_digits
// Brief    : Signed binary to sign + BCD, shift-and-add-3, one bit per clock
// Revision : 1.0
// ============================================================================
module coef_to_digits #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 5
) (
  input  wire logic         clk,
  input  wire logic         reset,
  coef_to_digits_if.slave   bus
);
  localparam int c_ACC_W = 4 * (DIGITS + 1);
  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0]  c_LAST_STEP = c_CNT_W'(WIDTH - 1);
  localparam logic [4*DIGITS-1:0] c_ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_start_conv;
  logic                   w_last_step;

  logic                   r_sign;
  logic [WIDTH-1:0]       r_mag;
  logic [c_ACC_W-1:0]     r_acc;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [4*DIGITS-1:0]    r_digits;
  logic                   r_plus;
  logic                   r_ovf;
  logic                   r_done;

  logic [WIDTH-1:0]       w_mag_in;
  logic [c_ACC_W-1:0]     w_adj;
  logic [c_ACC_W-1:0]     w_acc_next;
  logic                   w_ovf;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_conv = 1'b0;
    w_last_step  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_conv = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (r_cnt == c_LAST_STEP) begin
          w_last_step  = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Most negative input negates to itself, which is the correct unsigned magnitude.
  assign w_mag_in = bus.value[WIDTH-1] ? (~bus.value + WIDTH'(1)) : bus.value;

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  assign w_acc_next = {w_adj[c_ACC_W-2:0], r_mag[WIDTH-1]};
  // A bit falling off the guard nibble is also a magnitude too large to show.
  assign w_ovf      = w_adj[c_ACC_W-1] | (|w_acc_next[c_ACC_W-1 -: 4]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
      r_plus   <= 1'b1;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last_step;
      if (w_start_conv) begin
        r_sign <= bus.value[WIDTH-1];
        r_mag  <= w_mag_in;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == S_CONV) begin
        r_acc  <= w_acc_next;
        r_mag  <= {r_mag[WIDTH-2:0], 1'b0};
        r_cnt  <= r_cnt + c_CNT_W'(1);
      end
      if (w_last_step) begin
        r_plus   <= ~r_sign;
        r_ovf    <= w_ovf;
        r_digits <= w_ovf ? c_ALL_NINES : w_acc_next[4*DIGITS-1:0];
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.digits   = r_digits;
  assign bus.plus     = r_plus;
  assign bus.overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_coef_to_digits.sv
`default_nettype none
// ============================================================================
// Module   : tb_coef_to_digits
// Brief    : Directed self-checking bench for the default and a 20-bit build
// Revision : 1.0
// ============================================================================
module tb_coef_to_digits;
  logic clk;
  logic reset;
  int   passes;
  int   total;

  coef_to_digits_if #(.WIDTH(17), .DIGITS(5)) b17 ();
  coef_to_digits_if #(.WIDTH(20), .DIGITS(5)) b20 ();

  coef_to_digits #(.WIDTH(17), .DIGITS(5)) u_dut17 (
    .clk   (clk),
    .reset (reset),
    .bus   (b17)
  );

  coef_to_digits #(.WIDTH(20), .DIGITS(5)) u_dut20 (
    .clk   (clk),
    .reset (reset),
    .bus   (b20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic conv17(input string tag, input logic [16:0] v,
                        input logic [19:0] exp_d, input logic exp_p);
    int n;
    int nb;
    b17.value = v;
    b17.start = 1'b1;
    tick();
    b17.start = 1'b0;
    b17.value = ~v;
    nb = (b17.busy === 1'b1) ? 1 : 0;
    n  = 0;
    while (b17.done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (b17.busy === 1'b1) nb++;
    end
    check({tag, ".latency"}, n, 17);
    check({tag, ".digits"}, {12'd0, b17.digits}, {12'd0, exp_d});
    check({tag, ".plus"}, {31'd0, b17.plus}, {31'd0, exp_p});
    check({tag, ".ovf"}, {31'd0, b17.overflow}, 32'd0);
    tick();
    check({tag, ".done_drop"}, {31'd0, b17.done}, 32'd0);
    check({tag, ".busy_drop"}, {31'd0, b17.busy}, 32'd0);
    check({tag, ".busy_cycles"}, nb, 18);
  endtask

  task automatic conv20(input string tag, input logic [19:0] v,
                        input logic [19:0] exp_d, input logic exp_p, input logic exp_o);
    int n;
    b20.value = v;
    b20.start = 1'b1;
    tick();
    b20.start = 1'b0;
    n = 0;
    while (b20.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 20);
    check({tag, ".digits"}, {12'd0, b20.digits}, {12'd0, exp_d});
    check({tag, ".plus"}, {31'd0, b20.plus}, {31'd0, exp_p});
    check({tag, ".ovf"}, {31'd0, b20.overflow}, {31'd0, exp_o});
    tick();
    check({tag, ".done_drop"}, {31'd0, b20.done}, 32'd0);
  endtask

  initial begin
    int nd;
    passes    = 0;
    total     = 0;
    reset     = 1'b1;
    b17.start = 1'b0;
    b17.value = '0;
    b20.start = 1'b0;
    b20.value = '0;
    repeat (3) tick();

    check("rst.busy", {31'd0, b17.busy}, 32'd0);
    check("rst.done", {31'd0, b17.done}, 32'd0);
    check("rst.digits", {12'd0, b17.digits}, 32'd0);
    check("rst.plus", {31'd0, b17.plus}, 32'd1);
    check("rst.ovf", {31'd0, b17.overflow}, 32'd0);
    reset = 1'b0;
    tick();

    conv17("p12345", 17'd12345, 20'h12345, 1'b1);
    conv17("nmin", 17'h10000, 20'h65536, 1'b0);
    conv17("pmax", 17'd65535, 20'h65535, 1'b1);
    conv17("neg1", 17'h1FFFF, 20'h00001, 1'b0);

    // Abort with reset partway through converting -42.
    b17.value = 17'h1FFD6;
    b17.start = 1'b1;
    tick();
    b17.start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("abort.busy", {31'd0, b17.busy}, 32'd0);
    check("abort.digits", {12'd0, b17.digits}, 32'd0);
    check("abort.plus", {31'd0, b17.plus}, 32'd1);
    check("abort.done", {31'd0, b17.done}, 32'd0);
    reset = 1'b0;
    nd = 0;
    repeat (30) begin
      tick();
      if (b17.done === 1'b1) nd++;
    end
    check("abort.no_done", nd, 0);

    // Zero, with start re-pulsed during CONV and DONE.
    b17.value = '0;
    b17.start = 1'b1;
    tick();
    b17.start = 1'b0;
    repeat (4) tick();
    b17.value = 17'd777;
    b17.start = 1'b1;
    tick();
    b17.start = 1'b0;
    check("zero.hold_digits", {12'd0, b17.digits}, 32'd0);
    repeat (11) tick();
    b17.start = 1'b1;
    tick();
    check("zero.done", {31'd0, b17.done}, 32'd1);
    check("zero.digits", {12'd0, b17.digits}, 32'd0);
    check("zero.plus", {31'd0, b17.plus}, 32'd1);
    tick();
    check("zero.done_drop", {31'd0, b17.done}, 32'd0);
    check("zero.idle", {31'd0, b17.busy}, 32'd0);
    tick();
    b17.start = 1'b0;
    check("s777.accepted", {31'd0, b17.busy}, 32'd1);
    nd = 0;
    while (b17.done !== 1'b1 && nd < 40) begin
      tick();
      nd++;
    end
    check("s777.latency", nd, 17);
    check("s777.digits", {12'd0, b17.digits}, 32'h00777);
    check("s777.plus", {31'd0, b17.plus}, 32'd1);
    tick();

    conv20("w20.p100000", 20'd100000, 20'h99999, 1'b1, 1'b1);
    conv20("w20.n99999", 20'hE7961, 20'h99999, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/coef_to_digits.md
Name: coef_to_digits

Overview:
- Sequential signed-binary to sign+BCD converter (shift-and-add-3, one bit per clock).
- Turns a stored polynomial coefficient back into five decimal digits and a sign, for the 7-segment digit/sign drivers and the on-screen digit editor.
- It is the inverse of the digit-entry path, which builds a coefficient from digits.
- Sits between the coefficient register file and the display/editor logic on the 25 MHz pixel-clock domain.

Parameters:
- WIDTH, 17: width of the signed two's-complement input value.
- DIGITS, 5: number of BCD output digits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of value; sampled only in IDLE.
- value  input  WIDTH  signed coefficient to convert.
- busy  output  1  high while a conversion is in progress (CONV or DONE state).
- done  output  1  single-cycle pulse; digits, plus and overflow are valid and newly updated.
- digits  output  4*DIGITS  packed BCD; digit i at [4i+3:4i]; digit 0 = ones.
- plus  output  1  1 = value non-negative, 0 = negative; same encoding as the sign display driver.
- overflow  output  1  magnitude exceeded 10^DIGITS-1 on the last conversion.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, digits=0, plus=1, overflow=0.
  - Internal shift register and counter are cleared.
  - Reset overrides start on the same edge.
- States: IDLE -> CONV -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1, latch sign = value[WIDTH-1].
  - Latch mag = |value| as an unsigned WIDTH-bit number. The most negative value (-2^(WIDTH-1)) is representable; default -65536 gives mag 65536.
  - Clear BCD accumulator (DIGITS+1 nibbles; the extra nibble is used for overflow detection). Clear step counter. Go to CONV.
- CONV, one step per edge, WIDTH steps total:
  - Every accumulator nibble >= 5 gets +3.
  - Then {acc, mag} shifts left 1.
  - The counter increments. On the edge completing step WIDTH, go to DONE.
- Entry into DONE (same edge as the last step):
  - Register outputs: plus = ~sign, digits = low DIGITS nibbles, done=1.
  - overflow = (top nibble != 0). If overflow, digits are forced to all 9s.
- DONE lasts exactly one cycle. Next edge: done=0, go to IDLE.
- Latency: start sampled at edge 0 -> done high after edge WIDTH, low after edge WIDTH+1. Default is 17 cycles start-to-done.
- busy:
  - Goes high after edge 0 and low after edge WIDTH+1.
  - Throughput is one conversion per WIDTH+2 cycles.
- start while busy (CONV or DONE) is ignored: not queued, no effect on the running conversion.
- value changes after the start edge do not affect the result (latched at start).
- digits, plus and overflow hold their previous values throughout CONV. They change only on the done edge.
- Zero converts to all-zero digits with plus=1 (no negative zero).
- Reset mid-conversion aborts immediately. Outputs return to reset values and no done pulse is emitted.
- With default parameters overflow can never assert (max magnitude 65536 < 99999). It exists for wider WIDTH builds.

Test Plan:
- Positive value: reset, then start=1 for one cycle with value=12345.
  - done is high exactly 17 cycles later, for 1 cycle.
  - digits = 1,2,3,4,5 (nibbles 4..0); plus=1; overflow=0; busy high for 18 cycles.
- Negative extremes:
  - value=-65536 -> digits 6,5,5,3,6, plus=0.
  - value=-1 -> 0,0,0,0,1, plus=0.
  - value=65535 -> 6,5,5,3,5, plus=1.
- Zero and start-while-busy:
  - value=0 -> all-zero digits, plus=1.
  - Re-pulse start with value=777 at cycles 5 and 17 of that conversion: both are ignored, result is still 0.
  - A start in the first IDLE cycle after done does produce 7,7,7.
- Reset mid-conversion:
  - Start value=-42, assert reset at cycle 8.
  - Next cycle: busy=0, digits=0, plus=1. No done pulse within 30 cycles.
- Overflow build (WIDTH=20):
  - value=100000 -> overflow=1, digits all 9, plus=1.
  - value=-99999 -> overflow=0, digits 9,9,9,9,9, plus=0; done after 20 cycles.
